// File: rtl/instr_fetch_queue_pkg.sv
// Shared configuration and helpers for the instruction fetch queue.
// Build-wide defaults; a project config header may define these first.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef IFQ_DEPTH
`define IFQ_DEPTH 4
`endif

package instr_fetch_queue_pkg;

  localparam int IFQ_ADDR_W_DEF  = `ADDR_W;
  localparam int IFQ_INSTR_W_DEF = `INSTR_W;
  localparam int IFQ_DEPTH_DEF   = `IFQ_DEPTH;

  // What to do with the memory response seen this cycle.
  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_DROP = 2'd1,
    RESP_FILL = 2'd2
  } resp_action_e;

  // A response is discarded when it belongs to a flushed path: either the
  // flush is happening right now, or older stale reads are still pending.
  function automatic resp_action_e classify_resp(input logic valid,
                                                 input logic flush,
                                                 input logic drop_pending);
    if (!valid) begin
      return RESP_IDLE;
    end
    if (flush || drop_pending) begin
      return RESP_DROP;
    end
    return RESP_FILL;
  endfunction

endpackage

// File: rtl/ifq_slot_array.sv
// Slot storage for the fetch queue: pc/instr/filled per slot, with an
// allocate port, a fill port, a combinational head read and clear-all.
module ifq_slot_array #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               clear_all_i,
  input  logic               alloc_en_i,
  input  logic [PTR_W-1:0]   alloc_idx_i,
  input  logic [ADDR_W-1:0]  alloc_pc_i,
  input  logic               fill_en_i,
  input  logic [PTR_W-1:0]   fill_idx_i,
  input  logic [INSTR_W-1:0] fill_instr_i,
  input  logic [PTR_W-1:0]   head_idx_i,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic               head_filled_o
);

  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]   filled_q;
  logic [DEPTH-1:0]   alloc_hit;
  logic [DEPTH-1:0]   fill_hit;

  // Per-slot write-port decode.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign alloc_hit[gi] = alloc_en_i && (alloc_idx_i == PTR_W'(gi));
      assign fill_hit[gi]  = fill_en_i  && (fill_idx_i  == PTR_W'(gi));
    end
  endgenerate

  // Filled bits: allocation empties a slot, a response fills it, flush empties all.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      filled_q <= '0;
    end else if (clear_all_i) begin
      filled_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_hit[i]) begin
          filled_q[i] <= 1'b0;
        end else if (fill_hit[i]) begin
          filled_q[i] <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset; the filled bits qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_hit[i]) begin
        pc_q[i] <= alloc_pc_i;
      end
      if (fill_hit[i]) begin
        instr_q[i] <= fill_instr_i;
      end
    end
  end

  assign head_pc_o     = pc_q[head_idx_i];
  assign head_instr_o  = instr_q[head_idx_i];
  assign head_filled_o = filled_q[head_idx_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue between fetch and decode: issues a memory read per
// fetch request, keeps {pc, instr} in program order, and discards wrong-path
// responses after a branch flush.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = IFQ_DEPTH_DEF,
  parameter int ADDR_W  = IFQ_ADDR_W_DEF,
  parameter int INSTR_W = IFQ_INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_instr_req,
  output logic               o_stall,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic               i_mem_valid,
  input  logic [INSTR_W-1:0] i_mem_data,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  input  logic               i_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(2 * DEPTH + 1);
  // Stall one slot early: fe's request is registered, so one more arrives.
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(DEPTH - 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic         alloc;
  logic         pop;
  logic         head_filled;
  resp_action_e resp_act;

  assign alloc      = i_instr_req & ~flush & ~clr;
  assign o_mem_req  = alloc;
  assign o_mem_addr = i_pc;
  assign o_stall    = (count_q >= STALL_AT);
  assign o_valid    = (count_q != '0) & head_filled;
  // Decode must not consume during flush; ignore a pop that cycle.
  assign pop        = o_valid & i_ready & ~flush;
  assign resp_act   = classify_resp(i_mem_valid, flush, drop_q != '0);

  ifq_slot_array #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .PTR_W   (PTR_W)
  ) u_slots (
    .clk           (clk),
    .clr           (clr),
    .clear_all_i   (flush),
    .alloc_en_i    (alloc),
    .alloc_idx_i   (tail_q),
    .alloc_pc_i    (i_pc),
    .fill_en_i     (resp_act == RESP_FILL),
    .fill_idx_i    (fill_q),
    .fill_instr_i  (i_mem_data),
    .head_idx_i    (head_q),
    .head_pc_o     (o_pc),
    .head_instr_o  (o_instr),
    .head_filled_o (head_filled)
  );

  // Next-state for pointers and counters; flush overrides everything else.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      // Every read still in flight after this cycle belongs to the old path.
      outst_d = outst_q - OUT_W'(i_mem_valid);
      drop_d  = CNT_W'(outst_d);
    end else begin
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
      tail_d  = tail_q + PTR_W'(alloc);
      head_d  = head_q + PTR_W'(pop);
      outst_d = outst_q + OUT_W'(alloc) - OUT_W'(i_mem_valid);
      if (resp_act == RESP_DROP) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (resp_act == RESP_FILL) begin
        fill_d = fill_q + PTR_W'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

endmodule
